dram_stream_reader: RTL and testbench

//  Read-side sequencer for a distributed RAM (combinational read, clocked write).
//  - On a start command, walks len_i consecutive addresses from base_addr_i on the RAM read port.
//  - Each word is registered and presented on a valid/ready stream with a last flag.
//  - Sits between a RAM instance and a consumer (DMA, debug dump, CSR bank readout).

---
 rtl/dram_stream_reader_pkg.sv | 17 +
 rtl/dram_rd_oreg.sv | 42 ++++
 rtl/dram_stream_reader.sv | 145 ++++++++++++++
 tb/tb_dram_stream_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_stream_reader_pkg.sv
// dram_stream_reader_pkg
//   Shared definitions for the distributed-RAM stream reader and its writer
//   counterpart: FSM state encodings and the width helper for word counts.
//   No ports (package).
package dram_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  // A word count must reach 2**aw (a full-array transfer), so it needs one
  // bit more than an address.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/dram_rd_oreg.sv
// dram_rd_oreg
//   Valid/ready output holding register for the stream reader. Owns the
//   stream outputs; word and last flag stay frozen while stalled.
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   load           capture data/last and present them (valid goes high)
//   data, last     word and final-word flag to capture
//   ready          consumer ready; drains the register when not reloading
//   m_valid_o      word valid
//   m_data_o       held word
//   m_last_o       held final-word flag
module dram_rd_oreg #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic [XLEN-1:0] data,
  input  logic            last,
  input  logic            ready,
  output logic            m_valid_o,
  output logic [XLEN-1:0] m_data_o,
  output logic            m_last_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else if (load) begin
      m_valid_o <= 1'b1;
      m_data_o  <= data;
      m_last_o  <= last;
    end else if (m_valid_o && ready) begin
      // Drain without reload: data keeps its last value, only qualifiers drop.
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_stream_reader.sv
// dram_stream_reader
//   Read-side sequencer for a distributed RAM with combinational read. A start
//   command walks len_i consecutive addresses from base_addr_i and streams each
//   registered word out on a valid/ready interface, flagging the final word.
//   Build option: DRAM_RD_WRAP_EN -- addresses wrap modulo ENTRY_NUM and any
//   in-array base is accepted; without it a command running past the end of
//   the array is rejected with err_o.
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           command strobe (only honoured when idle)
//   base_addr_i       first address of the command
//   len_i             word count, 0..ENTRY_NUM
//   busy_o            command in flight
//   done_o            one-cycle pulse: command complete
//   err_o             one-cycle pulse: command rejected
//   ram_addr_o        RAM read address
//   ram_data_i        RAM read data, valid in the same cycle
//   m_valid_o/m_ready_i/m_data_o/m_last_o   output word stream
module dram_stream_reader
  import dram_stream_reader_pkg::*;
#(
  parameter int ENTRY_NUM = 32,
  parameter int XLEN      = 32,
  parameter int AWDTH     = $clog2(ENTRY_NUM)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [AWDTH-1:0]        base_addr_i,
  input  logic [cnt_w(AWDTH)-1:0] len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [AWDTH-1:0]        ram_addr_o,
  input  logic [XLEN-1:0]         ram_data_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [XLEN-1:0]         m_data_o,
  output logic                    m_last_o
);

  localparam int CW = cnt_w(AWDTH);

  logic [1:0]       state_q;
  logic [AWDTH-1:0] addr_q;
  logic [AWDTH-1:0] addr_nxt;
  logic [CW-1:0]    rem_q;
  logic             done_q;
  logic             err_q;
  logic             load;
  logic             last_word;
  logic             bad_len;
  logic             bad_range;

  assign busy_o     = (state_q == ST_RUN) || (state_q == ST_LAST);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign ram_addr_o = addr_q;

  // Fetch whenever the output register is empty or being drained this edge.
  assign load      = (state_q == ST_RUN) && (!m_valid_o || m_ready_i);
  assign last_word = (rem_q == CW'(1));
  assign bad_len   = (len_i > CW'(ENTRY_NUM));

`ifdef DRAM_RD_WRAP_EN
  localparam bit POW2 = (ENTRY_NUM == (1 << AWDTH));

  // Only a non-power-of-two array can see an address past its end.
  assign bad_range = (CW'(base_addr_i) >= CW'(ENTRY_NUM));

  always_comb begin
    addr_nxt = addr_q + AWDTH'(1);
    if (!POW2 && (addr_q == AWDTH'(ENTRY_NUM - 1)))
      addr_nxt = '0;
  end
`else
  localparam int SW = CW + 1;

  logic [SW-1:0] span;

  // One extra bit so base+len cannot overflow before the compare.
  assign span      = SW'(base_addr_i) + SW'(len_i);
  assign bad_range = (span > SW'(ENTRY_NUM));
  assign addr_nxt  = addr_q + AWDTH'(1);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (bad_len || bad_range) begin
              err_q <= 1'b1;
            end else if (len_i == '0) begin
              // Empty command completes without any stream beat.
              done_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              addr_q  <= base_addr_i;
              rem_q   <= len_i;
            end
          end
        end
        ST_RUN: begin
          if (load) begin
            addr_q <= addr_nxt;
            rem_q  <= rem_q - CW'(1);
            if (last_word) state_q <= ST_LAST;
          end
        end
        ST_LAST: begin
          // Final word already fetched; wait for the consumer to take it.
          if (m_valid_o && m_ready_i) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dram_rd_oreg #(
    .XLEN (XLEN)
  ) u_oreg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (load),
    .data      (ram_data_i),
    .last      (last_word),
    .ready     (m_ready_i),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o)
  );

endmodule

// File: tb/tb_dram_stream_reader.sv
// tb_dram_stream_reader
//   Directed bench for dram_stream_reader with a behavioural distributed RAM
//   (combinational read, clocked write). Expected beats are queued when a
//   command is issued; a negedge monitor pops and compares each handshake and
//   checks stall stability.
module tb_dram_stream_reader;

  localparam int EN = 32;
  localparam int XL = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy, done, err;
  logic [AW-1:0] raddr;
  logic [XL-1:0] rdata;
  logic          mvalid;
  logic          m_ready;
  logic [XL-1:0] mdata;
  logic          mlast;

  logic [XL-1:0] ram [EN];
  logic          we;
  logic [AW-1:0] waddr;
  logic [XL-1:0] wdata;

  always #5 clk = ~clk;

  always @(posedge clk) if (we) ram[waddr] <= wdata;
  assign rdata = ram[raddr];

  dram_stream_reader #(.ENTRY_NUM(EN), .XLEN(XL), .AWDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .ram_addr_o  (raddr),
    .ram_data_i  (rdata),
    .m_valid_o   (mvalid),
    .m_ready_i   (m_ready),
    .m_data_o    (mdata),
    .m_last_o    (mlast)
  );

  typedef struct {
    logic [XL-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    bcyc_q[$];
  beat_t e;
  int    n_pass = 0, n_total = 0;
  int    done_cnt = 0, err_cnt = 0, beat_cnt = 0, done_cyc = 0, cyc = 0;
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [XL-1:0] pd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Monitor: scoreboard pop on every handshake, stall-stability checks.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(mvalid), 64'(1));
        chk("hold_data",  64'(mdata),  64'(pd));
        chk("hold_last",  64'(mlast),  64'(pl));
      end
      if (mvalid && m_ready) begin
        beat_cnt++;
        bcyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got data 0x%0h, want no beat", mdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(mdata), 64'(e.d));
          chk("beat_last", 64'(mlast), 64'(e.l));
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cnt++;
      pv = mvalid; pr = m_ready; pd = mdata; pl = mlast;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [XL-1:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    exp_q.push_back(b);
  endtask

  // Queue the expected words of a base/len walk over the initial RAM image.
  task automatic push_run(input int b, input int n);
    for (int i = 0; i < n; i++) push(XL'(((b + i) % EN) * 32'h11), (i == n - 1));
  endtask

  // Called at posedge+1; the command is accepted on the next edge.
  task automatic do_cmd(input int b, input int l);
    start = 1'b1; base = AW'(b); len = (AW+1)'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      n_total++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", nm, n);
    end
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, r0, t0, n;
    for (int i = 0; i < EN; i++) ram[i] = XL'(i) * 32'h11;
    rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0;
    repeat (3) tick();

    chk("rst_busy",   64'(busy),   64'(0));
    chk("rst_done",   64'(done),   64'(0));
    chk("rst_err",    64'(err),    64'(0));
    chk("rst_valid",  64'(mvalid), 64'(0));
    chk("rst_last",   64'(mlast),  64'(0));
    chk("rst_data",   64'(mdata),  64'(0));
    chk("rst_addr",   64'(raddr),  64'(0));
    rst = 1'b0;
    tick();

    // base=4 len=3, ready high: back-to-back beats, done one cycle after last
    d0 = done_cnt; b0 = beat_cnt; bcyc_q.delete();
    push_run(4, 3);
    do_cmd(4, 3);
    t0 = cyc;
    wait_idle("t1");
    chk("t1_done", 64'(done_cnt - d0), 64'(1));
    chk("t1_beats", 64'(beat_cnt - b0), 64'(3));
    if (bcyc_q.size() == 3) begin
      chk("t1_first_lat", 64'(bcyc_q[0] - t0), 64'(1));
      chk("t1_last_lat",  64'(bcyc_q[2] - t0), 64'(3));
    end
    chk("t1_done_lat", 64'(done_cyc - t0), 64'(4));

    // Same command with the consumer stalling on the first word
    d0 = done_cnt; b0 = beat_cnt;
    m_ready = 1'b0;
    push_run(4, 3);
    do_cmd(4, 3);
    n = 0;
    while (!mvalid && n < 20) begin tick(); n++; end
    tick(); tick();
    chk("t2_held_data", 64'(mdata), 64'h44);
    chk("t2_held_valid", 64'(mvalid), 64'(1));
    m_ready = 1'b1;
    wait_idle("t2");
    chk("t2_done", 64'(done_cnt - d0), 64'(1));
    chk("t2_beats", 64'(beat_cnt - b0), 64'(3));

    // len=0: done only
    d0 = done_cnt; b0 = beat_cnt; r0 = err_cnt;
    do_cmd(7, 0);
    wait_idle("t3");
    chk("t3_done", 64'(done_cnt - d0), 64'(1));
    chk("t3_beats", 64'(beat_cnt - b0), 64'(0));
    chk("t3_err", 64'(err_cnt - r0), 64'(0));

    // len=33 > ENTRY_NUM: error only
    d0 = done_cnt; b0 = beat_cnt; r0 = err_cnt;
    do_cmd(0, 33);
    wait_idle("t4");
    chk("t4_err", 64'(err_cnt - r0), 64'(1));
    chk("t4_done", 64'(done_cnt - d0), 64'(0));
    chk("t4_beats", 64'(beat_cnt - b0), 64'(0));

    // base=30 len=4 crosses the array end
    d0 = done_cnt; b0 = beat_cnt; r0 = err_cnt;
`ifdef DRAM_RD_WRAP_EN
    push(32'h1FE, 1'b0); push(32'h20F, 1'b0); push(32'h0, 1'b0); push(32'h11, 1'b1);
`endif
    do_cmd(30, 4);
    wait_idle("t5");
`ifdef DRAM_RD_WRAP_EN
    chk("t5_done", 64'(done_cnt - d0), 64'(1));
    chk("t5_err", 64'(err_cnt - r0), 64'(0));
    chk("t5_beats", 64'(beat_cnt - b0), 64'(4));
`else
    chk("t5_err", 64'(err_cnt - r0), 64'(1));
    chk("t5_done", 64'(done_cnt - d0), 64'(0));
    chk("t5_beats", 64'(beat_cnt - b0), 64'(0));
`endif

    // Reset after the 2nd beat of a len=8 command, then a fresh command
    d0 = done_cnt; b0 = beat_cnt;
    push_run(0, 8);
    do_cmd(0, 8);
    n = 0;
    while ((beat_cnt - b0) < 2 && n < 50) begin @(negedge clk); #2; n++; end
    rst = 1'b1;
    tick();
    chk("t6_valid", 64'(mvalid), 64'(0));
    chk("t6_last",  64'(mlast),  64'(0));
    chk("t6_data",  64'(mdata),  64'(0));
    chk("t6_busy",  64'(busy),   64'(0));
    chk("t6_addr",  64'(raddr),  64'(0));
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("t6_no_done", 64'(done_cnt - d0), 64'(0));
    d0 = done_cnt; b0 = beat_cnt;
    push_run(9, 2);
    do_cmd(9, 2);
    wait_idle("t6b");
    chk("t6b_done", 64'(done_cnt - d0), 64'(1));
    chk("t6b_beats", 64'(beat_cnt - b0), 64'(2));

    // start while busy is ignored
    d0 = done_cnt; b0 = beat_cnt; r0 = err_cnt;
    push_run(12, 4);
    do_cmd(12, 4);
    do_cmd(2, 1);
    wait_idle("t7");
    chk("t7_done", 64'(done_cnt - d0), 64'(1));
    chk("t7_err", 64'(err_cnt - r0), 64'(0));
    chk("t7_beats", 64'(beat_cnt - b0), 64'(4));

    // Write to addr 5 on the edge the word loads: old value, then re-read
    d0 = done_cnt; b0 = beat_cnt;
    push(32'h55, 1'b1);
    do_cmd(5, 1);
    we = 1'b1; waddr = AW'(5); wdata = 32'hDEAD;
    tick();
    we = 1'b0;
    wait_idle("t8a");
    push(32'hDEAD, 1'b1);
    do_cmd(5, 1);
    wait_idle("t8b");
    chk("t8_done", 64'(done_cnt - d0), 64'(2));
    chk("t8_beats", 64'(beat_cnt - b0), 64'(2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
